uart_rx_frame_collector: RTL

Receive front end of the data path. Deserialises the 8N1 serial stream on rx_data, paced by the baud generator's bclk, into bytes. Stores exactly NUM_BYTES bytes in an internal buffer, then raises all_done. The downstream processing/transmit stage reads the buffer through a registered read port.

---
 rtl/uart_rx_frame_collector_pkg.sv | 21 ++
 rtl/uart_rx_frame_collector_edge_strobe.sv | 31 +++
 rtl/uart_rx_frame_collector.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_collector_pkg.sv
// Shared 8N1 framing definitions for the UART receive and transmit stages.
package uart_rx_frame_collector_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_IDLE      = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4,
    ST_DONE      = 3'd5
  } rx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   FRAME_BITS = 10;

  function automatic logic is_busy(input rx_state_e state);
    return (state != ST_OFF) && (state != ST_DONE);
  endfunction

endpackage

// File: rtl/uart_rx_frame_collector_edge_strobe.sv
// One-clk strobe on a chosen edge of a clk-synchronous baud clock.
module uart_rx_edge_strobe #(
  parameter bit FALLING = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_strobe
);

  logic r_sig_q;

  // previous-cycle copy of the baud clock
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sig_q <= 1'b0;
    end else begin
      r_sig_q <= i_sig;
    end
  end

  // edge detect against the delayed copy
  always_comb begin
    if (FALLING) begin
      o_strobe = r_sig_q & ~i_sig;
    end else begin
      o_strobe = ~r_sig_q & i_sig;
    end
  end

endmodule

// File: rtl/uart_rx_frame_collector.sv
// 8N1 receiver that collects a fixed-size block of bytes into a readable buffer.
module uart_rx_frame_collector
  import uart_rx_frame_collector_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_BYTES = 18,
  parameter int ADDR_W    = $clog2(NUM_BYTES)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_bclk,
  input  logic              i_start,
  input  logic              i_rx_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_byte_valid,
  output logic [DATA_W-1:0] o_byte_data,
  output logic [ADDR_W:0]   o_byte_count,
  output logic              o_busy,
  output logic              o_all_done,
  output logic              o_frame_err
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;

  rx_state_e         r_state;
  rx_state_e         w_state_nxt;
  logic [DATA_W-1:0] r_shreg;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  r_byte_count;
  logic [CNT_W-1:0]  w_count_inc;
  logic [DATA_W-1:0] r_byte_data;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_byte_valid;
  logic              r_busy;
  logic              r_all_done;
  logic              r_frame_err;
  logic              w_strobe;
  logic              w_commit;
  logic              w_bad_stop;
  logic              w_shift;
  logic              w_bit_clr;
  logic [DATA_W-1:0] r_buf [DEPTH];

  uart_rx_edge_strobe #(.FALLING(1'b1)) u_strobe (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sig   (i_bclk),
    .o_strobe(w_strobe)
  );

  assign w_count_inc = r_byte_count + CNT_W'(1);

  // next-state decode; start overrides every state and drops any frame in flight
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_bad_stop  = 1'b0;
    w_shift     = 1'b0;
    w_bit_clr   = 1'b0;
    if (i_start) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt = ST_OFF;
        end
        ST_IDLE: begin
          if (w_strobe && (i_rx_data == START_BIT)) begin
            w_state_nxt = ST_DATA;
            w_bit_clr   = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (w_strobe) begin
            w_shift = 1'b1;
            if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
              w_state_nxt = ST_STOP;
            end else begin
              w_state_nxt = ST_DATA;
            end
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
        ST_STOP: begin
          if (w_strobe && (i_rx_data == STOP_BIT)) begin
            w_commit = 1'b1;
            if (w_count_inc == CNT_W'(NUM_BYTES)) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else if (w_strobe) begin
            w_bad_stop  = 1'b1;
            w_state_nxt = ST_WAIT_HIGH;
          end else begin
            w_state_nxt = ST_STOP;
          end
        end
        ST_WAIT_HIGH: begin
          // a held-low line (break) must not be decoded as 0x00 frames
          if (w_strobe && (i_rx_data == STOP_BIT)) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_WAIT_HIGH;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        default: begin
          w_state_nxt = ST_OFF;
        end
      endcase
    end
  end

  // state, datapath and status registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_OFF;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_byte_count <= '0;
      r_byte_data  <= '0;
      r_rd_data    <= '0;
      r_byte_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_all_done   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_busy       <= is_busy(w_state_nxt);
      r_byte_valid <= w_commit;
      r_rd_data    <= r_buf[i_rd_addr];
      if (w_bit_clr) begin
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      end
      if (w_shift) begin
        r_shreg <= {i_rx_data, r_shreg[DATA_W-1:1]};
      end
      if (i_start) begin
        r_byte_count <= '0;
        r_all_done   <= 1'b0;
        r_frame_err  <= 1'b0;
      end else begin
        if (w_commit) begin
          r_byte_count <= w_count_inc;
          r_byte_data  <= r_shreg;
          if (w_count_inc == CNT_W'(NUM_BYTES)) begin
            r_all_done <= 1'b1;
          end
        end
        if (w_bad_stop) begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  // byte buffer: not reset, written only on a committed frame
  always_ff @(posedge i_clk) begin
    if (w_commit) begin
      r_buf[r_byte_count[ADDR_W-1:0]] <= r_shreg;
    end
  end

  assign o_rd_data    = r_rd_data;
  assign o_byte_valid = r_byte_valid;
  assign o_byte_data  = r_byte_data;
  assign o_byte_count = r_byte_count;
  assign o_busy       = r_busy;
  assign o_all_done   = r_all_done;
  assign o_frame_err  = r_frame_err;

endmodule
